// File: rtl/commit_retire_ctrl.sv
// commit_retire_ctrl: in-order ROB retirement with exception walk-back and flush
package commit_retire_pkg;
    localparam int PHY_W = 6;
    typedef struct packed {
        logic             finish;
        logic             has_exception;
        logic             rd_valid;
        logic [PHY_W-1:0] old_phy_reg_id;
        logic [PHY_W-1:0] new_phy_reg_id;
        logic [31:0]      pc;
    } rob_item_t;
endpackage

module commit_retire_ctrl
    import commit_retire_pkg::*;
#(
    parameter int COMMIT_WIDTH     = 4,
    parameter int ROB_ID_WIDTH     = 5,
    parameter int PHY_REG_ID_WIDTH = PHY_W
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [ROB_ID_WIDTH-1:0]                        rob_commit_retire_head_id,
    input  logic                                           rob_commit_retire_head_id_valid,
    output logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0]      commit_rob_retire_id,
    input  rob_item_t [COMMIT_WIDTH-1:0]                   rob_commit_retire_data,
    input  logic [COMMIT_WIDTH-1:0]                        rob_commit_retire_id_valid,
    output logic [COMMIT_WIDTH-1:0]                        commit_rob_retire_pop,
    input  logic [ROB_ID_WIDTH-1:0]                        rob_commit_flush_tail_id,
    output logic [ROB_ID_WIDTH-1:0]                        commit_rob_flush_id,
    input  rob_item_t                                      rob_commit_flush_data,
    output logic                                           commit_rob_flush,
    output logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  commit_freelist_release_id,
    output logic [COMMIT_WIDTH-1:0]                        commit_freelist_release_valid,
    output logic [PHY_REG_ID_WIDTH-1:0]                    commit_rat_restore_id,
    output logic                                           commit_rat_restore_valid,
    output logic [31:0]                                    commit_redirect_pc,
    output logic                                           commit_redirect_valid,
    output logic [63:0]                                    commit_retire_count
);
    typedef enum logic [1:0] {RETIRE, FLUSH_WALK, FLUSH_DONE} state_t;

    state_t                               state, state_n;
    logic [ROB_ID_WIDTH-1:0]              exc_id, exc_lane_id;
    logic [31:0]                          exc_pc, exc_lane_pc;
    logic                                 exc_hit, blocked, lane_valid;
    logic [$clog2(COMMIT_WIDTH+1)-1:0]    pop_cnt;
    logic [COMMIT_WIDTH-1:0]              unused_lane;
    logic                                 unused_flush;

    assign commit_rat_restore_id = rob_commit_flush_data.new_phy_reg_id;
    assign commit_redirect_pc    = exc_pc;
    assign unused_flush = ^{rob_commit_flush_data.finish, rob_commit_flush_data.has_exception,
                            rob_commit_flush_data.old_phy_reg_id, rob_commit_flush_data.pc};

    // Per-lane ids and release ids; the lane id wraps naturally at ROB_SIZE
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_rob_retire_id[i]       = rob_commit_retire_head_id + ROB_ID_WIDTH'(i);
            commit_freelist_release_id[i] = rob_commit_retire_data[i].old_phy_reg_id;
            unused_lane[i]                = ^rob_commit_retire_data[i].new_phy_reg_id;
        end
    end

    // Retire the qualifying prefix; the first blocking lane is inspected for an exception
    always_comb begin
        state_n                       = state;
        commit_rob_retire_pop         = '0;
        commit_freelist_release_valid = '0;
        commit_rat_restore_valid      = 1'b0;
        commit_rob_flush              = 1'b0;
        commit_redirect_valid         = 1'b0;
        exc_hit                       = 1'b0;
        exc_lane_id                   = '0;
        exc_lane_pc                   = '0;
        blocked                       = 1'b0;
        lane_valid                    = 1'b0;
        pop_cnt                       = '0;
        if (state == RETIRE) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                lane_valid = rob_commit_retire_head_id_valid & rob_commit_retire_id_valid[i]
                           & rob_commit_retire_data[i].finish;
                if (!blocked) begin
                    if (lane_valid && !rob_commit_retire_data[i].has_exception) begin
                        commit_rob_retire_pop[i]         = 1'b1;
                        commit_freelist_release_valid[i] = rob_commit_retire_data[i].rd_valid;
                        pop_cnt                          = pop_cnt + 1'b1;
                    end else begin
                        blocked     = 1'b1;
                        exc_hit     = lane_valid;
                        exc_lane_id = commit_rob_retire_id[i];
                        exc_lane_pc = rob_commit_retire_data[i].pc;
                    end
                end
            end
            state_n = exc_hit ? FLUSH_WALK : RETIRE;
        end else if (state == FLUSH_WALK) begin
            commit_rat_restore_valid = rob_commit_flush_data.rd_valid;
            state_n = (commit_rob_flush_id == exc_id) ? FLUSH_DONE : FLUSH_WALK;
        end else begin
            commit_rob_flush      = 1'b1;
            commit_redirect_valid = 1'b1;
            state_n               = RETIRE;
        end
    end

    // State, retire counter, exception capture and the tail-to-head walk pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= RETIRE;
            commit_retire_count <= '0;
            exc_id              <= '0;
            exc_pc              <= '0;
            commit_rob_flush_id <= '0;
        end else begin
            state               <= state_n;
            commit_retire_count <= commit_retire_count + 64'(pop_cnt);
            if (exc_hit) begin
                exc_id              <= exc_lane_id;
                exc_pc              <= exc_lane_pc;
                commit_rob_flush_id <= rob_commit_flush_tail_id;
            end else if (state == FLUSH_WALK && commit_rob_flush_id != exc_id) begin
                commit_rob_flush_id <= commit_rob_flush_id - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_retire_ctrl.sv
// tb_commit_retire_ctrl: vector table, corner sequences and random run against a reference model
module tb_commit_retire_ctrl;
    import commit_retire_pkg::*;

    logic                 clk = 1'b0, rst = 1'b1;
    logic [4:0]           head, tail;
    logic                 hv;
    logic [3:0]           idv, fin, exc, rdv;
    logic [5:0]           old_ids [4];
    logic [31:0]          pcs [4];
    rob_item_t [3:0]      rdata;
    rob_item_t            fdata;
    logic [3:0][4:0]      retire_id;
    logic [3:0]           pop, rel_v;
    logic [4:0]           fid;
    logic                 flush, restore_v, redir_v;
    logic [3:0][5:0]      rel_id;
    logic [5:0]           restore_id;
    logic [31:0]          redir_pc;
    logic [63:0]          count;

    int tests = 0, fails = 0;
    int mode = 0;
    longint unsigned m_count = 0;
    logic [4:0]  m_exc_id, m_walk;
    logic [31:0] m_pc;
    logic        obs_flush;
    logic [4:0]  obs_fid;
    logic [31:0] obs_pc;

    always #5 clk = ~clk;

    commit_retire_ctrl dut (
        .clk(clk), .rst(rst),
        .rob_commit_retire_head_id(head), .rob_commit_retire_head_id_valid(hv),
        .commit_rob_retire_id(retire_id), .rob_commit_retire_data(rdata),
        .rob_commit_retire_id_valid(idv), .commit_rob_retire_pop(pop),
        .rob_commit_flush_tail_id(tail), .commit_rob_flush_id(fid),
        .rob_commit_flush_data(fdata), .commit_rob_flush(flush),
        .commit_freelist_release_id(rel_id), .commit_freelist_release_valid(rel_v),
        .commit_rat_restore_id(restore_id), .commit_rat_restore_valid(restore_v),
        .commit_redirect_pc(redir_pc), .commit_redirect_valid(redir_v),
        .commit_retire_count(count)
    );

    // ROB model: lane entries from bench arrays, walk entry derived from the requested id
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i].finish         = fin[i];
            rdata[i].has_exception  = exc[i];
            rdata[i].rd_valid       = rdv[i];
            rdata[i].old_phy_reg_id = old_ids[i];
            rdata[i].new_phy_reg_id = 6'(i);
            rdata[i].pc             = pcs[i];
        end
        fdata.finish         = 1'b1;
        fdata.has_exception  = 1'b0;
        fdata.rd_valid       = fid[0] ^ fid[2];
        fdata.old_phy_reg_id = 6'd0;
        fdata.new_phy_reg_id = {1'b1, fid};
        fdata.pc             = 32'd0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] h, input logic v, input logic [3:0] iv,
                         input logic [3:0] f, input logic [3:0] e, input logic [3:0] r,
                         input logic [4:0] t);
        head = h; hv = v; idv = iv; fin = f; exc = e; rdv = r; tail = t;
        for (int i = 0; i < 4; i++) begin
            old_ids[i] = 6'($urandom);
            pcs[i]     = $urandom;
        end
    endtask

    // One clock: model check at the falling edge, model update after the rising edge
    task automatic cycle();
        int n;
        logic [3:0] ep;
        logic go_exc;
        n = 0;
        go_exc = 1'b0;
        @(negedge clk);
        obs_flush = flush;
        obs_fid   = fid;
        obs_pc    = redir_pc;
        chk("count", count, m_count);
        for (int i = 0; i < 4; i++) chk("lane_id", retire_id[i], 64'((head + 5'(i)) % 32));
        if (mode == 0) begin
            while (n < 4 && hv && idv[n] && fin[n] && !exc[n]) n++;
            ep = 4'((1 << n) - 1);
            chk("pop", pop, ep);
            chk("rel_valid", rel_v, ep & rdv);
            for (int i = 0; i < 4; i++)
                if (ep[i] && rdv[i]) chk("rel_id", rel_id[i], old_ids[i]);
            chk("flush_idle", {flush, redir_v, restore_v}, 0);
            if (n < 4 && hv && idv[n] && fin[n] && exc[n]) begin
                go_exc   = 1'b1;
                m_exc_id = head + 5'(n);
                m_pc     = pcs[n];
                m_walk   = tail;
            end
        end else if (mode == 1) begin
            chk("walk_quiet", {pop, rel_v, flush, redir_v}, 0);
            chk("walk_id", fid, m_walk);
            chk("restore_valid", restore_v, m_walk[0] ^ m_walk[2]);
            if (m_walk[0] ^ m_walk[2]) chk("restore_id", restore_id, {1'b1, m_walk});
        end else begin
            chk("done_pulse", {pop, rel_v, flush, redir_v, restore_v}, 64'b0000_0000_1_1_0);
            chk("redirect_pc", redir_pc, m_pc);
        end
        @(posedge clk);
        if (rst) begin
            mode = 0;
            m_count = 0;
        end else if (mode == 0) begin
            m_count += 64'(n);
            if (go_exc) mode = 1;
        end else if (mode == 1) begin
            if (m_walk == m_exc_id) mode = 2;
            else m_walk = m_walk - 5'd1;
        end else mode = 0;
        #1;
    endtask

    typedef struct {
        logic [4:0]  head;
        logic        hv;
        logic [3:0]  idv, fin, exc, rdv, exp_pop, exp_rel;
        logic [19:0] exp_ids;
    } vec_t;

    vec_t vecs [8];
    int walk;

    initial begin
        vecs[0] = '{5'd3,  1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1011, 4'b1111, 4'b1011, {5'd6, 5'd5, 5'd4, 5'd3}};
        vecs[1] = '{5'd3,  1'b1, 4'b1111, 4'b1101, 4'b0000, 4'b1111, 4'b0001, 4'b0001, {5'd6, 5'd5, 5'd4, 5'd3}};
        vecs[2] = '{5'd4,  1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, {5'd7, 5'd6, 5'd5, 5'd4}};
        vecs[3] = '{5'd30, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0110, 4'b1111, 4'b0110, {5'd1, 5'd0, 5'd31, 5'd30}};
        vecs[4] = '{5'd8,  1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, {5'd11, 5'd10, 5'd9, 5'd8}};
        vecs[5] = '{5'd12, 1'b1, 4'b0011, 4'b1111, 4'b0000, 4'b1111, 4'b0011, 4'b0011, {5'd15, 5'd14, 5'd13, 5'd12}};
        vecs[6] = '{5'd31, 1'b1, 4'b1111, 4'b1101, 4'b0100, 4'b0001, 4'b0001, 4'b0001, {5'd2, 5'd1, 5'd0, 5'd31}};
        vecs[7] = '{5'd0,  1'b1, 4'b1111, 4'b1110, 4'b0001, 4'b1111, 4'b0000, 4'b0000, {5'd3, 5'd2, 5'd1, 5'd0}};

        drive(5'd0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", count, 0);
        chk("reset_strobes", {pop, rel_v, flush, redir_v, restore_v}, 0);
        chk("reset_flush_id", fid, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].head, vecs[v].hv, vecs[v].idv, vecs[v].fin, vecs[v].exc, vecs[v].rdv, 5'd20);
            #1;
            chk("vec_pop", pop, vecs[v].exp_pop);
            chk("vec_rel", rel_v, vecs[v].exp_rel);
            chk("vec_ids", retire_id, vecs[v].exp_ids);
            cycle();
        end

        drive(5'd5, 1'b1, 4'b1111, 4'b1111, 4'b0100, 4'b1111, 5'd12);
        pcs[2] = 32'h8000_1000;
        #1 chk("exc_pop", pop, 4'b0011);
        cycle();
        hv = 1'b0;
        walk = 0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (obs_flush) break;
            chk("walk_seq", obs_fid, 64'(5'(12 - n)));
            walk++;
        end
        chk("walk_len", walk, 6);
        chk("redirect_seen", obs_flush, 1);
        chk("redirect_val", obs_pc, 32'h8000_1000);
        cycle();
        chk("flush_once", obs_flush, 0);

        drive(5'd9, 1'b1, 4'b1111, 4'b0001, 4'b0001, 4'b1111, 5'd9);
        cycle();
        hv = 1'b0;
        walk = 0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (obs_flush) break;
            walk++;
        end
        chk("head_exc_walk_len", walk, 1);

        drive(5'd0, 1'b1, 4'b1111, 4'b1111, 4'b0001, 4'b1111, 5'd20);
        cycle();
        hv = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("rst_no_flush", obs_flush, 0);
        end
        chk("rst_count", count, 0);

        for (int c = 0; c < 400; c++) begin
            int nv;
            nv = $urandom_range(0, 4);
            drive(5'($urandom), nv > 0 && ($urandom_range(0, 7) != 0), 4'((1 << nv) - 1),
                  4'($urandom) | 4'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0,
                  4'($urandom), 5'd0);
            tail = head + 5'(nv > 0 ? nv - 1 : 0) + 5'($urandom_range(0, 31 - nv));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
